// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BREAK
`endif
    } tx_state_t;

    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    localparam logic UART_IDLE_LVL = 1'b1;

    // Index of the final data bit in a frame for a given word-length code.
    function automatic logic [2:0] last_data_idx(input logic [1:0] data_bits);
        logic [2:0] idx;
        idx = 3'd7;
        case (data_bits)
            DBITS_5: idx = 3'd4;
            DBITS_6: idx = 3'd5;
            DBITS_7: idx = 3'd6;
            DBITS_8: idx = 3'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter; bit_end is high while the count sits at zero.
// Shared between the TX engine and the future RX engine.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_val,
    output logic                 bit_end
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from the TX FIFO registered read port and frames them onto txd.
// Defining UART_TX_BREAK_EN adds break_req and a line-break state.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic [1:0]            data_bits,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  stop2,
    input  logic                  cts_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
`ifdef UART_TX_BREAK_EN
    input  logic                  break_req,
`endif
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  tx_done
);

    tx_state_t            state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic [1:0]           data_bits_q, data_bits_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 stop2_q, stop2_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 rd_en_q, rd_en_d;
    logic                 baud_load;
    logic [DIV_WIDTH-1:0] baud_val;
    logic                 bit_end;
    logic                 frame_go;
`ifdef UART_TX_BREAK_EN
    logic                 hold_q, hold_d;
`endif

    uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (baud_load),
        .load_val (baud_val),
        .bit_end  (bit_end)
    );

    assign frame_go = !fifo_empty && !cts_n;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        par_d       = par_q;
        data_bits_d = data_bits_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        stop2_d     = stop2_q;
        div_d       = div_q;
        txd_d       = txd_q;
        done_d      = 1'b0;
        baud_load   = 1'b0;
        baud_val    = div_q;
`ifdef UART_TX_BREAK_EN
        hold_d      = hold_q;
`endif

        case (state_q)
            IDLE: begin
                txd_d = UART_IDLE_LVL;
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    state_d = BREAK;
                    txd_d   = 1'b0;
                    hold_d  = 1'b0;
                end else if (!(hold_q && !bit_end)) begin
                    hold_d = 1'b0;
                    if (frame_go) state_d = FETCH;
                end
`else
                if (frame_go) state_d = FETCH;
`endif
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                // rd_data is valid now, one cycle after the pop strobe.
                shift_d     = fifo_rd_data[7:0];
                data_bits_d = data_bits;
                par_en_d    = parity_en;
                par_odd_d   = parity_odd;
                stop2_d     = stop2;
                div_d       = baud_div;
                baud_load   = 1'b1;
                baud_val    = baud_div;
                txd_d       = 1'b0;
                state_d     = START;
            end
            START: begin
                if (bit_end) begin
                    baud_load = 1'b1;
                    txd_d     = shift_q[0];
                    par_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_load = 1'b1;
                    if (bit_cnt_q == last_data_idx(data_bits_q)) begin
                        stop_cnt_d = 1'b0;
                        if (par_en_q) begin
                            txd_d   = par_q ^ par_odd_q;
                            state_d = PARITY;
                        end else begin
                            txd_d   = UART_IDLE_LVL;
                            state_d = STOP;
                        end
                    end else begin
                        txd_d     = shift_q[0];
                        par_d     = par_q ^ shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    baud_load  = 1'b1;
                    txd_d      = UART_IDLE_LVL;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                        baud_load  = 1'b1;
                    end else begin
                        done_d = 1'b1;
`ifdef UART_TX_BREAK_EN
                        if (break_req) begin
                            state_d = BREAK;
                            txd_d   = 1'b0;
                        end else if (frame_go) begin
                            state_d = FETCH;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = frame_go ? FETCH : IDLE;
`endif
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                txd_d = 1'b0;
                if (!break_req) begin
                    // Guarantee one idle-high bit period after the break.
                    txd_d     = UART_IDLE_LVL;
                    hold_d    = 1'b1;
                    baud_load = 1'b1;
                    baud_val  = baud_div;
                    state_d   = IDLE;
                end
            end
`endif
            default: begin
                txd_d   = UART_IDLE_LVL;
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        rd_en_d = (state_d == FETCH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            par_q       <= 1'b0;
            data_bits_q <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            stop2_q     <= 1'b0;
            div_q       <= '0;
            txd_q       <= UART_IDLE_LVL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
            hold_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            par_q       <= par_d;
            data_bits_q <= data_bits_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            stop2_q     <= stop2_d;
            div_q       <= div_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
`ifdef UART_TX_BREAK_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign txd        = txd_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign fifo_rd_en = rd_en_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: FIFO model, expected-frame scoreboard, per-cycle txd capture.
// The break test is included only when UART_TX_BREAK_EN is defined.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic [1:0]  data_bits;
    logic        parity_en, parity_odd, stop2, cts_n;
    logic        fifo_empty, fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        txd, tx_busy, tx_done;
`ifdef UART_TX_BREAK_EN
    logic        break_req;
`endif

    typedef struct {
        logic [63:0] wave;
        int          len;
    } frame_t;

    frame_t     exp_q[$];
    logic [7:0] mem [0:15];
    int         push_cnt = 0;
    int         pop_cnt = 0;
    int         empty_pop_cnt = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_div     (baud_div),
        .data_bits    (data_bits),
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
        .stop2        (stop2),
        .cts_n        (cts_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
`ifdef UART_TX_BREAK_EN
        .break_req    (break_req),
`endif
        .txd          (txd),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    // Registered-read FIFO model: data appears the cycle after the pop strobe.
    assign fifo_empty = (push_cnt == pop_cnt);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (push_cnt == pop_cnt) begin
                empty_pop_cnt <= empty_pop_cnt + 1;
            end else begin
                fifo_rd_data <= mem[pop_cnt[3:0]];
                pop_cnt      <= pop_cnt + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected txd waveform, one entry per clock, from the current configuration inputs.
    function automatic frame_t make_frame(input logic [7:0] b);
        frame_t     f;
        logic [11:0] bits;
        logic       par;
        int         nb, n, per;
        bits = '0;
        par  = 1'b0;
        n    = 0;
        nb   = 5 + int'(data_bits);
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin
            bits[n] = b[i];
            par     = par ^ b[i];
            n++;
        end
        if (parity_en) begin
            bits[n] = par ^ parity_odd; n++;
        end
        bits[n] = 1'b1; n++;
        if (stop2) begin
            bits[n] = 1'b1; n++;
        end
        per    = int'(baud_div) + 1;
        f.wave = '0;
        for (int i = 0; i < n * per; i++) f.wave[i] = bits[i / per];
        f.len = n * per;
        return f;
    endfunction

    task automatic push(input logic [7:0] b);
        mem[push_cnt[3:0]] = b;
        exp_q.push_back(make_frame(b));
        push_cnt++;
    endtask

    task automatic wait_start(input string tag, output int idle);
        logic ok;
        ok   = 1'b0;
        idle = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                ok = 1'b1;
                break;
            end
            idle++;
        end
        check({tag, "_start_seen"}, ok, 1'b1);
    endtask

    // Called on the first START cycle; ends on the tx_done cycle.
    task automatic capture(input string tag, input int cts_at);
        frame_t      f;
        logic [63:0] obs;
        int          busy_lo, done_hi;
        f       = exp_q.pop_front();
        obs     = '0;
        busy_lo = 0;
        done_hi = 0;
        for (int i = 0; i < f.len; i++) begin
            if (i > 0) @(negedge clk);
            if (i == cts_at) cts_n = 1'b1;
            obs[i] = txd;
            if (tx_busy !== 1'b1) busy_lo++;
            if (tx_done !== 1'b0) done_hi++;
        end
        check({tag, "_wave"}, obs, f.wave);
        check({tag, "_busy"}, busy_lo, 0);
        check({tag, "_no_early_done"}, done_hi, 0);
        @(negedge clk);
        check({tag, "_done"}, tx_done, 1'b1);
    endtask

    initial begin
        int     idle, p0, low;
        frame_t dummy;

        rst_n      = 1'b0;
        baud_div   = 16'd3;
        data_bits  = 2'd3;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        cts_n      = 1'b0;
`ifdef UART_TX_BREAK_EN
        break_req  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1, 0x55, 4 clocks per bit
        p0 = pop_cnt;
        push(8'h55);
        wait_start("basic", idle);
        check("basic_latency", idle, 2);
        capture("basic", -1);
        check("basic_pops", pop_cnt - p0, 1);
        repeat (2) @(negedge clk);

        // 8E1 0xA5; config changed mid-frame must not matter
        parity_en = 1'b1;
        push(8'hA5);
        wait_start("par_even", idle);
        baud_div  = 16'd0;
        parity_en = 1'b0;
        data_bits = 2'd0;
        stop2     = 1'b1;
        capture("par_even", -1);
        baud_div   = 16'd3;
        data_bits  = 2'd3;
        parity_en  = 1'b1;
        stop2      = 1'b0;
        parity_odd = 1'b1;
        push(8'hA5);
        wait_start("par_odd", idle);
        capture("par_odd", -1);

        // 5 data bits, 2 stop bits, 1 clock per bit
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        data_bits  = 2'd0;
        stop2      = 1'b1;
        baud_div   = 16'd0;
        push(8'hFF);
        wait_start("w5s2", idle);
        capture("w5s2", -1);
        repeat (2) @(negedge clk);

        // three back-to-back frames
        data_bits = 2'd3;
        stop2     = 1'b0;
        baud_div  = 16'd1;
        p0 = pop_cnt;
        push(8'h3C);
        push(8'h81);
        push(8'hE7);
        wait_start("stream0", idle);
        capture("stream0", -1);
        wait_start("stream1", idle);
        check("stream1_gap", idle + 1, 2);
        capture("stream1", -1);
        wait_start("stream2", idle);
        check("stream2_gap", idle + 1, 2);
        capture("stream2", -1);
        repeat (5) @(negedge clk);
        check("stream_pops", pop_cnt - p0, 3);
        check("stream_idle_busy", tx_busy, 1'b0);

        // cts_n raised during data bit 2 (the 4th bit) of frame 1
        baud_div = 16'd3;
        p0 = pop_cnt;
        push(8'h12);
        push(8'hC4);
        wait_start("flow1", idle);
        capture("flow1", 13);
        repeat (12) @(negedge clk);
        check("flow_hold_pops", pop_cnt - p0, 1);
        check("flow_hold_busy", tx_busy, 1'b0);
        check("flow_hold_txd", txd, 1'b1);
        cts_n = 1'b0;
        wait_start("flow2", idle);
        check("flow2_latency", idle, 2);
        capture("flow2", -1);
        check("flow_pops", pop_cnt - p0, 2);

        // reset during a data bit
        push(8'h00);
        wait_start("rst_mid", idle);
        repeat (12) @(negedge clk);
        check("rst_mid_pre_txd", txd, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_txd", txd, 1'b1);
        check("rst_mid_busy", tx_busy, 1'b0);
        rst_n = 1'b1;
        dummy = exp_q.pop_front();
        repeat (4) @(negedge clk);
        check("rst_mid_after_txd", txd, 1'b1);

`ifdef UART_TX_BREAK_EN
        break_req = 1'b1;
        push(8'h99);
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (txd === 1'b0 && tx_busy === 1'b1) low++;
        end
        break_req = 1'b0;
        check("break_low", low, 20);
        wait_start("after_break", idle);
        check("break_idle", idle, 6);
        capture("after_break", -1);
`else
        low = 0;
`endif

        check("no_pop_when_empty", empty_pop_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Read-side consumer of the UART TX AsyncFIFO. It pops bytes through the FIFO's registered read port (rd_en / rd_data / empty) and serialises each one onto txd.
- Frame format: start bit, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Honours the cts_n flow-control input.
- Sits in the UART tx clock domain, between the FIFO read port and the pad.

Parameters:
- DATA_WIDTH, 8, width of the FIFO read data; only the low 8 bits are used.
- DIV_WIDTH, 16, width of the baud divisor.

Ports:
- clk  in  1  tx-domain clock, same clock as the FIFO rd_clk.
- rst_n  in  1  reset; synchronous, active-low.
- baud_div  in  DIV_WIDTH  bit period minus 1, in clk cycles.
- data_bits  in  2  0=5, 1=6, 2=7, 3=8 data bits.
- parity_en  in  1  append a parity bit.
- parity_odd  in  1  1=odd parity, 0=even parity.
- stop2  in  1  1=two stop bits, 0=one.
- cts_n  in  1  peer clear-to-send, active-low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop strobe.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data; valid one cycle after fifo_rd_en.
- txd  out  1  serial output; idles high.
- tx_busy  out  1  high whenever state is not IDLE.
- tx_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset values (rst_n=0 sampled at a posedge): txd=1, fifo_rd_en=0, tx_busy=0, tx_done=0, state=IDLE, counters=0. All outputs are registered.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- Transitions:
  - IDLE -> FETCH when fifo_empty=0 and cts_n=0.
  - FETCH -> LOAD.
  - LOAD -> START.
  - START -> DATA.
  - DATA -> PARITY if parity_en, else DATA -> STOP.
  - PARITY -> STOP.
  - STOP -> FETCH if fifo_empty=0 and cts_n=0 (streaming), else STOP -> IDLE.
- fifo_rd_en is high for exactly the one cycle spent in FETCH. Because the FIFO registers rd_data, LOAD captures fifo_rd_data[7:0] into the shift register.
- In LOAD, data_bits, parity_en, parity_odd, stop2 and baud_div are latched. Changing these inputs mid-frame has no effect until the next frame.
- Latency: with condition edge E0, txd=0 is registered at E2, i.e. two clocks after E0.
- Bit timing:
  - Each start, data, parity and stop bit lasts exactly baud_div+1 clocks.
  - baud_div=0 gives 1 clock per bit.
  - A down-counter reloads at every bit boundary.
- Data bits: shifted out LSB first; the count comes from the latched data_bits.
- Parity: XOR of the transmitted data bits only, inverted when parity_odd=1.
- Stop: txd=1 for 1 or 2 bit periods.
  - tx_done pulses on the cycle after the last stop clock.
  - In streaming mode the FETCH/LOAD cycles add 2 extra clocks of txd=1 between frames.
- cts_n is sampled only at frame boundaries (IDLE and end of STOP). Deasserting it mid-frame never truncates the frame.
- fifo_empty mid-frame is ignored. No pop is ever issued while fifo_empty=1.
- Reset mid-frame: txd=1 at the next edge and the frame is abandoned. A byte already popped is lost.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined: adds input break_req (1 bit).
  - In IDLE, or at the end of STOP, break_req=1 takes priority over FETCH.
  - Enters state BREAK and drives txd=0 while break_req stays high.
  - After break_req falls, txd returns to 1 and the block holds IDLE for one full bit period before the next FETCH.
  - tx_busy=1 throughout.
- Undefined: no break_req port and no BREAK state; txd=0 only in START and on data/parity zeros.

Decomposition:
- Package uart_pkg:
  - state enum tx_state_t.
  - Data-bits encoding constants.
  - UART_IDLE_LVL=1.
- One sub-module, uart_baud_gen:
  - Loadable down-counter, DIV_WIDTH wide.
  - Emits bit_end when the count reaches 0 and reloads on start.
  - Can be reused by the future RX engine.

Test Plan:
- Basic frame: baud_div=3, 8N1, FIFO holds 0x55, cts_n=0.
  - fifo_rd_en pulses once.
  - txd: 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks, 40 clocks in all.
  - tx_done pulses once.
- Even parity: 0xA5, 8E1, baud_div=3.
  - txd: 0,1,0,1,0,0,1,0,1, parity 0, stop 1.
  - 11 bits = 44 clocks.
  - Repeat with parity_odd=1: parity bit = 1.
- Word length and stop bits: 5 data bits, 2 stop bits, baud_div=0, byte 0xFF.
  - txd: 0,1,1,1,1,1,1,1, i.e. start, 5 data and 2 stop bits over 8 clocks.
  - tx_busy stays high for 8 clocks.
- Streaming: 3 bytes queued.
  - Three back-to-back frames with exactly 2 idle-high clocks between them.
  - Exactly 3 pops; fifo_rd_en never high while fifo_empty=1.
- Flow control: raise cts_n during bit 3 of frame 1 with 2 bytes queued.
  - Frame 1 completes, then the block sits in IDLE with no pop.
  - Frame 2 starts 2 clocks after cts_n returns to 0.
- Reset and break:
  - rst_n=0 mid-DATA: txd=1 and tx_busy=0 after one edge.
  - With UART_TX_BREAK_EN: break_req held high 20 clocks gives txd low for 20 clocks, then one idle bit period before the next frame.
